sha2_round_engine: RTL
======================

// Module: sha2_round_engine
// PURPOSE
//  SHA-256 compression stage directly downstream of the message padder.
//  - Consumes the padded 32-bit word stream (shaf_rvalid/shaf_rready/shaf_rdata) in 16-word blocks.
//  - Runs 64 rounds per block, one round per cycle, and accumulates the 256-bit digest.
//  - Pulses hash_done once the final block is folded in; the pad FSM and register interface consume it.
// PARAMETERS
//  RoundsPerBlock  64  round count per 512-bit block; fixed by the algorithm, not to be overridden.
//  WordsPerBlock   16  32-bit words per block; fixed by the algorithm.
// PORTS
//  clk_i              in   1    clock
//  rst_ni             in   1    reset, asynchronous, active-low
//  wipe_secret        in   1    pulse: overwrite all secret state with wipe_v
//  wipe_v             in   32   wipe pattern
//  sha_en             in   1    engine enable; low forces idle
//  hash_start         in   1    pulse: load InitHash, begin new message
//  msg_feed_complete  in   1    padder has delivered the last word (level)
//  shaf_rvalid        in   1    padded word valid
//  shaf_rdata         in   32   padded word, big-endian word order
//  shaf_rready        out  1    engine accepts word
//  hash_done          out  1    one-cycle pulse: digest_o final
//  hash_busy          out  1    high in StFill with >0 words, StCompress, StUpdate
//  digest_o           out  256  H0 in [255:224] ... H7 in [31:0]
// BEHAVIOUR
//  - Reset values: shaf_rready=0, hash_done=0, hash_busy=0, digest_o=0, st=StIdle, word_cnt=0, round=0.
//  - FSM states and transitions:
//    StIdle -> StFill on sha_en & hash_start; on entry digest <= InitHash, word_cnt <= 0.
//    StFill: shaf_rready=1 while word_cnt<16. Handshake = shaf_rvalid & shaf_rready;
//      each handshake shifts the word into w[15], w[i] <= w[i+1]. On handshake with word_cnt==15 -> StCompress;
//      on entry abcdefgh <= digest, round <= 0.
//    StCompress: each cycle abcdefgh <= compress(w[0], K[round], abcdefgh);
//      w shifts, w[15] <= calc_w(w[0],w[1],w[9],w[14]); round++. At round==63 -> StUpdate.
//    StUpdate (1 cycle): digest[j] <= digest[j] + abcdefgh[j] mod 2^32, all eight words.
//      If msg_feed_complete -> StIdle and hash_done=1 next cycle; else -> StFill, word_cnt <= 0.
//  - Latency per block: 16 accept cycles (no backpressure) + 64 rounds + 1 update.
//    Back-to-back blocks resume word acceptance the cycle after StUpdate.
//  - K[round] = CubicRootPrime[(63-round)*32 +: 32]. Arithmetic is 32-bit and wraps; no carries kept.
//  - hash_start in any non-idle state (sha_en=1): abort the block, digest <= InitHash, -> StFill, word_cnt=0.
//  - sha_en low: next state StIdle, shaf_rready=0; digest_o is held.
//  - wipe_secret: digest, abcdefgh and all w[] <= wipe_v replicated. FSM, word_cnt and round are unchanged.
//    wipe_secret wins over any concurrent update in the same cycle.
//  - shaf_rvalid with no ready is ignored; shaf_rdata is sampled only on handshake.
//  - digest_o is combinational from the digest regs; software reads it only after hash_done.
// CONFIGURATION
//  SHA2_DIGEST_SWAP_EN defined: extra input digest_swap_i (1 bit). When high, each digest_o word
//    is presented byte-swapped via conv_endian; internal state is unaffected.
//  SHA2_DIGEST_SWAP_EN undefined: the port is absent and digest_o is always native big-endian word order.
// STRUCTURE
//  - sha2_pkg holds InitHash, CubicRootPrime, the functions rotr/shiftr/compress/calc_w/conv_endian,
//    and the FSM state encoding (StIdle, StFill, StCompress, StUpdate).
//  - Sub-module sha2_w_sched: 16x32 schedule shift register.
//    Load port for StFill, calc_w feedback for StCompress, wipe input; outputs w[0].
// TESTING
//  1. "abc" single padded block (61626380, 0 x13, 00000000, 00000018) -> hash_done after 81 cycles.
//     Expected digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  2. 448-bit "abcdbcdecdefghij...nopq" as two blocks -> digest 248d6a61 d20638b8 e5c02693 0c3e6039
//     a33ce459 64ff2167 f6ecedd4 19db06c1; hash_busy stays high between blocks.
//  3. Random shaf_rvalid gaps (50%) on test 1 -> identical digest; no word accepted while ready=0.
//  4. hash_start at round 30 of a block, then replay "abc" -> the "abc" digest, no residue.
//  5. wipe_secret with wipe_v=DEADBEEF in StIdle -> digest_o = {8{DEADBEEF}}; FSM stays StIdle.
//  6. With SHA2_DIGEST_SWAP_EN and digest_swap_i=1 on test 1 -> digest_o[255:224]=bf1678ba.
//     Also assert rst_ni mid-compress -> all outputs return to reset values.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: shared constants, types and helper functions for the SHA-256
// round engine.
//   InitHash        initial digest H0..H7, with H0 in [255:224]
//   CubicRootPrime  the 64 round constants, with K[0] in [2047:2016]
//   rotr / shiftr / compress / calc_w / conv_endian  round arithmetic
//   st_t            FSM state encoding
package sha2_pkg;

  localparam int RoundsPerBlock = 64;
  localparam int WordsPerBlock  = 16;

  // Word 7 holds H0 (or 'a'); word 0 holds H7 (or 'h').
  typedef logic [7:0][31:0] hash_t;

  typedef enum logic [1:0] {StIdle, StFill, StCompress, StUpdate} st_t;

  localparam hash_t InitHash = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [2047:0] CubicRootPrime = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] shiftr(input logic [31:0] x, input logic [4:0] n);
    return x >> n;
  endfunction

  function automatic hash_t compress(input logic [31:0] w, input logic [31:0] k, input hash_t h);
    logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, ch, maj, t1, t2;
    hash_t r;
    {a, b, c, d, e, f, g, hh} = h;
    s1  = rotr(e, 5'd6) ^ rotr(e, 5'd11) ^ rotr(e, 5'd25);
    ch  = (e & f) ^ (~e & g);
    t1  = hh + s1 + ch + k + w;
    s0  = rotr(a, 5'd2) ^ rotr(a, 5'd13) ^ rotr(a, 5'd22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + maj;
    r   = {t1 + t2, a, b, c, d + t1, e, f, g};
    return r;
  endfunction

  // Next schedule word from the 16-word window (w0 = W[t-16] ... w14 = W[t-2]).
  function automatic logic [31:0] calc_w(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w9, input logic [31:0] w14);
    logic [31:0] s0, s1;
    s0 = rotr(w1, 5'd7) ^ rotr(w1, 5'd18) ^ shiftr(w1, 5'd3);
    s1 = rotr(w14, 5'd17) ^ rotr(w14, 5'd19) ^ shiftr(w14, 5'd10);
    return w0 + s0 + w9 + s1;
  endfunction

  function automatic logic [31:0] conv_endian(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha2_round_engine_w_sched.sv
// sha2_round_engine_w_sched: 16x32 message schedule window.
//   load_i    shift data_i into w[15] (fill phase)
//   adv_i     shift with calc_w feedback into w[15] (compress phase)
//   wipe_i    overwrite every word with wipe_v_i (highest priority)
//   w0_o      current round's schedule word w[0]
module sha2_w_sched
  import sha2_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        adv_i,
  input  logic        wipe_i,
  input  logic [31:0] wipe_v_i,
  output logic [31:0] w0_o
);

  logic [15:0][31:0] w_q, w_d;

  always_comb begin
    w_d = w_q;
    if (load_i)     w_d = {data_i, w_q[15:1]};
    else if (adv_i) w_d = {calc_w(w_q[0], w_q[1], w_q[9], w_q[14]), w_q[15:1]};
    if (wipe_i)     w_d = {16{wipe_v_i}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) w_q <= '0;
    else         w_q <= w_d;
  end

  assign w0_o = w_q[0];

endmodule

// File: rtl/sha2_round_engine.sv
// sha2_round_engine: SHA-256 compression stage fed by the message padder.
// Accepts 16-word blocks on the shaf_* handshake, runs 64 rounds (one per
// cycle), folds the result into the digest, and pulses hash_done after the
// last block.
//   clk_i/rst_ni          clock, async active-low reset
//   wipe_secret/wipe_v    overwrite digest, working vars and schedule
//   sha_en                enable; low forces idle, digest held
//   hash_start            begin (or restart) a message from InitHash
//   msg_feed_complete     padder delivered last word (level)
//   shaf_rvalid/rdata/rready  padded word stream
//   hash_done             one-cycle pulse, digest final
//   hash_busy             message in progress
//   digest_o              H0 in [255:224] ... H7 in [31:0]
// Optional: SHA2_DIGEST_SWAP_EN adds digest_swap_i, which byte-swaps each
// digest_o word on the way out.
module sha2_round_engine
  import sha2_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wipe_secret,
  input  logic [31:0]  wipe_v,
  input  logic         sha_en,
  input  logic         hash_start,
  input  logic         msg_feed_complete,
  input  logic         shaf_rvalid,
  input  logic [31:0]  shaf_rdata,
  output logic         shaf_rready,
`ifdef SHA2_DIGEST_SWAP_EN
  input  logic         digest_swap_i,
`endif
  output logic         hash_done,
  output logic         hash_busy,
  output logic [255:0] digest_o
);

  st_t         st_q, st_d;
  logic [4:0]  word_cnt_q, word_cnt_d;
  logic [5:0]  round_q, round_d;
  hash_t       digest_q, digest_d;
  hash_t       abcd_q, abcd_d;
  logic        hash_done_q, hash_done_d;
  // Set while a multi-block message sits between blocks, so hash_busy does
  // not dip when the next block's fill starts at word_cnt 0.
  logic        msg_act_q, msg_act_d;

  logic        hs, w_adv;
  logic [31:0] w0, k_cur;

  // A restart takes priority over the word offered in the same cycle.
  assign shaf_rready = sha_en & ~hash_start & (st_q == StFill) &
                       (word_cnt_q < 5'(WordsPerBlock));
  assign hs          = shaf_rvalid & shaf_rready;
  assign w_adv       = sha_en & ~hash_start & (st_q == StCompress);
  assign k_cur       = CubicRootPrime[(11'd63 - 11'(round_q)) * 11'd32 +: 32];

  sha2_w_sched u_w_sched (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (hs),
    .data_i   (shaf_rdata),
    .adv_i    (w_adv),
    .wipe_i   (wipe_secret),
    .wipe_v_i (wipe_v),
    .w0_o     (w0)
  );

  always_comb begin
    st_d        = st_q;
    word_cnt_d  = word_cnt_q;
    round_d     = round_q;
    digest_d    = digest_q;
    abcd_d      = abcd_q;
    hash_done_d = 1'b0;
    msg_act_d   = msg_act_q;

    if (!sha_en) begin
      st_d      = StIdle;
      msg_act_d = 1'b0;
    end else if (hash_start) begin
      st_d       = StFill;
      digest_d   = InitHash;
      word_cnt_d = '0;
      msg_act_d  = 1'b0;
    end else begin
      unique case (st_q)
        StIdle: ;
        StFill: begin
          if (hs) begin
            word_cnt_d = word_cnt_q + 5'd1;
            if (word_cnt_q == 5'(WordsPerBlock - 1)) begin
              st_d    = StCompress;
              abcd_d  = digest_q;
              round_d = '0;
            end
          end
        end
        StCompress: begin
          abcd_d  = compress(w0, k_cur, abcd_q);
          round_d = round_q + 6'd1;
          if (round_q == 6'(RoundsPerBlock - 1)) st_d = StUpdate;
        end
        StUpdate: begin
          for (int j = 0; j < 8; j++) digest_d[j] = digest_q[j] + abcd_q[j];
          if (msg_feed_complete) begin
            st_d        = StIdle;
            hash_done_d = 1'b1;
            msg_act_d   = 1'b0;
          end else begin
            st_d       = StFill;
            word_cnt_d = '0;
            msg_act_d  = 1'b1;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    // Wipe overrides any same-cycle digest/working-var update.
    if (wipe_secret) begin
      digest_d = {8{wipe_v}};
      abcd_d   = {8{wipe_v}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q        <= StIdle;
      word_cnt_q  <= '0;
      round_q     <= '0;
      digest_q    <= '0;
      abcd_q      <= '0;
      hash_done_q <= 1'b0;
      msg_act_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      word_cnt_q  <= word_cnt_d;
      round_q     <= round_d;
      digest_q    <= digest_d;
      abcd_q      <= abcd_d;
      hash_done_q <= hash_done_d;
      msg_act_q   <= msg_act_d;
    end
  end

  assign hash_done = hash_done_q;
  assign hash_busy = ((st_q == StFill) && ((word_cnt_q != '0) || msg_act_q)) ||
                     (st_q == StCompress) || (st_q == StUpdate);

`ifdef SHA2_DIGEST_SWAP_EN
  always_comb begin
    for (int j = 0; j < 8; j++)
      digest_o[j*32 +: 32] = digest_swap_i ? conv_endian(digest_q[j]) : digest_q[j];
  end
`else
  assign digest_o = digest_q;
`endif

endmodule
